// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths and priority-state type for the register-file write arbiter.
package regfile_pkg;

    localparam int REG_AW     = 3;
    localparam int REG_DW     = 8;
    localparam int NUM_WR_REQ = 2;
    localparam int CNT_W      = 16;

    // Names the requester that wins when both are valid in the same cycle.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

endpackage : regfile_pkg

// File: rtl/regfile_wr_arbiter_if.sv
// Requester/register-file bundle for regfile_wr_arbiter.
// Grant counters and their clear exist only when REGFILE_WR_ARB_STATS_EN is defined.
interface regfile_wr_arbiter_if;
    import regfile_pkg::*;

    logic              req0_valid;
    logic [REG_AW-1:0] req0_addr;
    logic [REG_DW-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [REG_AW-1:0] req1_addr;
    logic [REG_DW-1:0] req1_data;
    logic              req1_ready;

    logic              wr_stall;

    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [REG_DW-1:0] wr_data;

`ifdef REGFILE_WR_ARB_STATS_EN
    logic [CNT_W-1:0]  gnt0_count;
    logic [CNT_W-1:0]  gnt1_count;
    logic              stats_clr;
`endif

    modport slave (
`ifdef REGFILE_WR_ARB_STATS_EN
        input  stats_clr,
        output gnt0_count, gnt1_count,
`endif
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  wr_stall,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data
    );

    modport master (
`ifdef REGFILE_WR_ARB_STATS_EN
        output stats_clr,
        input  gnt0_count, gnt1_count,
`endif
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output wr_stall,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data
    );

endinterface : regfile_wr_arbiter_if

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with the PRI0/PRI1 priority FSM.
// Grants are combinational; the favoured requester flips only on an actual grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_WR_REQ-1:0] i_valid,
    input  logic                  i_stall,
    output logic [NUM_WR_REQ-1:0] o_gnt
);

    pri_t                  r_state;
    pri_t                  w_state_nxt;
    logic [NUM_WR_REQ-1:0] w_gnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PRI0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_gnt       = '0;
        w_state_nxt = r_state;

        if (!i_stall) begin
            case (i_valid)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_state == PRI0) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end

        // Whoever was just served loses priority for the next contest.
        if (w_gnt[0]) begin
            w_state_nxt = PRI1;
        end else if (w_gnt[1]) begin
            w_state_nxt = PRI0;
        end
    end

    assign o_gnt = w_gnt;

endmodule : rr_arb2

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates two register-file write requesters onto one write port (1-cycle latency).
// Optional grant counters are built when REGFILE_WR_ARB_STATS_EN is defined.
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);

    logic [NUM_WR_REQ-1:0] w_gnt;
    logic                  w_take;
    logic [REG_AW-1:0]     w_sel_addr;
    logic [REG_DW-1:0]     w_sel_data;

    logic                  r_vld_p1;
    logic [REG_AW-1:0]     r_addr_p1;
    logic [REG_DW-1:0]     r_data_p1;

    rr_arb2 u_rr_arb2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid ({bus.req1_valid, bus.req0_valid}),
        .i_stall (bus.wr_stall),
        .o_gnt   (w_gnt)
    );

    assign bus.req0_ready = w_gnt[0];
    assign bus.req1_ready = w_gnt[1];
    assign w_take         = |w_gnt;

    always_comb begin
        w_sel_addr = bus.req0_addr;
        w_sel_data = bus.req0_data;
        if (w_gnt[1]) begin
            w_sel_addr = bus.req1_addr;
            w_sel_data = bus.req1_data;
        end
    end

    // Stage p1: accepted request becomes the write strobe; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_addr_p1 <= '0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= w_take;
            if (w_take) begin
                r_addr_p1 <= w_sel_addr;
                r_data_p1 <= w_sel_data;
            end
        end
    end

    assign bus.wr_en   = r_vld_p1;
    assign bus.wr_addr = r_addr_p1;
    assign bus.wr_data = r_data_p1;

`ifdef REGFILE_WR_ARB_STATS_EN
    logic [CNT_W-1:0] r_gnt0_cnt;
    logic [CNT_W-1:0] r_gnt1_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Clear wins over a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else if (bus.stats_clr) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else begin
            if (w_gnt[0]) r_gnt0_cnt <= sat_inc(r_gnt0_cnt);
            if (w_gnt[1]) r_gnt1_cnt <= sat_inc(r_gnt1_cnt);
        end
    end

    assign bus.gnt0_count = r_gnt0_cnt;
    assign bus.gnt1_count = r_gnt1_cnt;
`endif

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter against a behavioural arbitration model.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if bus ();

    regfile_wr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: favoured requester, expected write-port state, register file.
    int         fav;
    logic       exp_en;
    logic [2:0] exp_addr;
    logic [7:0] exp_data;
    logic [7:0] ref_mem [8];
    logic [7:0] tb_rf   [8];
    int         cnt0, cnt1;
    int         last_g;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) tb_rf[bus.wr_addr] <= bus.wr_data;
    end

    task automatic model_reset();
        fav      = 0;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        cnt0     = 0;
        cnt1     = 0;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.wr_stall   = 1'b0;
`ifdef REGFILE_WR_ARB_STATS_EN
        bus.stats_clr  = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, check ready, clock, check write port. Returns observed grant.
    task automatic step(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                        input logic st, output int obs);
        int g;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.wr_stall   = st;
        if (st || (!v0 && !v1)) g = -1;
        else if (v0 && v1)      g = fav;
        else                    g = v0 ? 0 : 1;
        last_g = g;
        #1;
        obs = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
        n_vec++;
        if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
            n_err++;
            $display("FAIL ready: got r0=%b r1=%b, expected grant %0d", bus.req0_ready, bus.req1_ready, g);
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            exp_en   = 1'b1;
            exp_addr = (g == 0) ? a0 : a1;
            exp_data = (g == 0) ? d0 : d1;
            ref_mem[exp_addr] = exp_data;
            fav = 1 - g;
        end else begin
            exp_en = 1'b0;
        end
        n_vec++;
        if (bus.wr_en !== exp_en || bus.wr_addr !== exp_addr || bus.wr_data !== exp_data) begin
            n_err++;
            $display("FAIL wr_port: got en=%b addr=%0d data=%h, expected en=%b addr=%0d data=%h",
                     bus.wr_en, bus.wr_addr, bus.wr_data, exp_en, exp_addr, exp_data);
        end
`ifdef REGFILE_WR_ARB_STATS_EN
        if (bus.stats_clr) begin
            cnt0 = 0; cnt1 = 0;
        end else begin
            if (g == 0 && cnt0 < 65535) cnt0++;
            if (g == 1 && cnt1 < 65535) cnt1++;
        end
        n_vec++;
        if (bus.gnt0_count !== 16'(cnt0) || bus.gnt1_count !== 16'(cnt1)) begin
            n_err++;
            $display("FAIL counters: got %0d/%0d, expected %0d/%0d", bus.gnt0_count, bus.gnt1_count, cnt0, cnt1);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd0 || bus.wr_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%h, expected 0/0/00", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        n_vec++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b%b, expected 00", bus.req0_ready, bus.req1_ready);
        end
`ifdef REGFILE_WR_ARB_STATS_EN
        n_vec++;
        if (bus.gnt0_count !== 16'd0 || bus.gnt1_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d, expected 0/0", bus.gnt0_count, bus.gnt1_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int obs;
        do_reset();
        step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, obs);
        n_vec++;
        if (obs !== 0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd3 || bus.wr_data !== 8'h5A) begin
            n_err++;
            $display("FAIL single_write: got grant=%0d en=%b addr=%0d data=%h, expected 0/1/3/5a", obs, bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, obs);
        n_vec++;
        if (bus.wr_en !== 1'b0 || bus.wr_data !== 8'h5A) begin
            n_err++;
            $display("FAIL single_idle: got en=%b data=%h, expected 0/5a", bus.wr_en, bus.wr_data);
        end
    endtask

    task automatic test_back_to_back();
        int obs;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'(i), 8'(8'h10 + i), 1'b1, 3'(i + 4), 8'(8'h80 + i), 1'b0, obs);
            n_vec++;
            if (obs !== (i % 2)) begin
                n_err++;
                $display("FAIL alternate_grant[%0d]: got %0d, expected %0d", i, obs, i % 2);
            end
        end
    endtask

    task automatic test_same_addr();
        int obs;
        do_reset();
        step(1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22, 1'b0, obs);
        n_vec++;
        if (bus.wr_data !== 8'h11) begin
            n_err++;
            $display("FAIL same_addr_first: got %h, expected 11", bus.wr_data);
        end
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h22, 1'b0, obs);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, obs);
        n_vec++;
        if (tb_rf[5] !== 8'h22) begin
            n_err++;
            $display("FAIL same_addr_final: got %h, expected 22", tb_rf[5]);
        end
    endtask

    task automatic test_stall();
        int obs;
        do_reset();
        step(1'b1, 3'd1, 8'hA1, 1'b0, 3'd0, 8'h00, 1'b0, obs);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'd2, 8'hB2, 1'b1, 3'd6, 8'hC6, 1'b1, obs);
            n_vec++;
            if (obs !== -1 || bus.wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL stall[%0d]: got grant=%0d en=%b, expected -1/0", i, obs, bus.wr_en);
            end
        end
        step(1'b1, 3'd2, 8'hB2, 1'b1, 3'd6, 8'hC6, 1'b0, obs);
        n_vec++;
        if (obs !== 1) begin
            n_err++;
            $display("FAIL stall_release: got grant %0d, expected 1", obs);
        end
    endtask

    task automatic test_reset_mid();
        int obs;
        do_reset();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h33, 1'b0, obs);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd0 || bus.wr_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: got en=%b addr=%0d data=%h, expected 0/0/00", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, obs);
        step(1'b1, 3'd7, 8'h77, 1'b1, 3'd7, 8'h88, 1'b0, obs);
        n_vec++;
        if (obs !== 0) begin
            n_err++;
            $display("FAIL reset_mid_first_grant: got %0d, expected 0", obs);
        end
    endtask

    task automatic test_random();
        int obs;
        logic p0, p1;
        logic [2:0] a0, a1;
        logic [7:0] d0, d1;
        p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!p0 && ($urandom % 3 != 0)) begin p0 = 1'b1; a0 = 3'($urandom); d0 = 8'($urandom); end
            if (!p1 && ($urandom % 3 != 0)) begin p1 = 1'b1; a1 = 3'($urandom); d1 = 8'($urandom); end
`ifdef REGFILE_WR_ARB_STATS_EN
            bus.stats_clr = ($urandom % 40 == 0);
`endif
            step(p0, a0, d0, p1, a1, d1, ($urandom % 5 == 0), obs);
            if (last_g == 0) p0 = 1'b0;
            if (last_g == 1) p1 = 1'b0;
        end
`ifdef REGFILE_WR_ARB_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, obs);
        for (int r = 0; r < 8; r++) begin
            n_vec++;
            if (tb_rf[r] !== ref_mem[r]) begin
                n_err++;
                $display("FAIL regfile[%0d]: got %h, expected %h", r, tb_rf[r], ref_mem[r]);
            end
        end
    endtask

`ifdef REGFILE_WR_ARB_STATS_EN
    task automatic test_stats();
        int obs;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 8'(i), 1'b0, 3'd0, 8'h00, 1'b0, obs);
        bus.stats_clr = 1'b1;
        step(1'b1, 3'd1, 8'h44, 1'b0, 3'd0, 8'h00, 1'b0, obs);
        bus.stats_clr = 1'b0;
        n_vec++;
        if (bus.gnt0_count !== 16'd0) begin
            n_err++;
            $display("FAIL stats_clr: got %0d, expected 0", bus.gnt0_count);
        end
        for (int i = 0; i < 65537; i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'(i), 1'b0, obs);
        n_vec++;
        if (bus.gnt1_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stats_saturate: got %h, expected ffff", bus.gnt1_count);
        end
    endtask
`endif

    initial begin
        for (int r = 0; r < 8; r++) begin
            tb_rf[r]   = 8'h00;
            ref_mem[r] = 8'h00;
        end
        idle_inputs();
        model_reset();
        last_g = -1;
        test_reset();
        test_single();
        test_back_to_back();
        test_same_addr();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef REGFILE_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter
